multi_cycle_controller: RTL and testbench
=========================================

# multi_cycle_controller

Main control unit for the multi-cycle RV32I datapath (lw, sw, R-type ALU, I-type ALU, beq, jal). It sits directly upstream of the datapath, consuming decoded instruction fields and the ALU zero flag. Each cycle it drives every datapath enable and mux select from a Moore state machine, plus an ALU operation decode. One instruction completes every 3–5 cycles.

## Interface
Parameters: none.

Ports:
- i_clk  input  1  core clock; all state updates on its rising edge.
- i_arst_n  input  1  asynchronous, active-low reset.
- i_operand  input  7  instruction_q[6:0].
- i_funct3  input  3  instruction_q[14:12].
- i_funct7bit5  input  1  instruction_q[30].
- i_zeroFlag  input  1  ALU zero flag, taken from the combinational ALU result.
- o_pcWriteEn  output  1  PC register load.
- o_instructionRegWrite  output  1  loads instruction_q and oldPc.
- o_addressSrc  output  1  memory address: 0 = pc, 1 = aluOutput_q.
- o_memWriteEn  output  1  memory write.
- o_regWriteEn  output  1  register file write.
- o_aluInputASel  output  2  0 = PC, 1 = OLD_PC, 2 = REG_READ_DATA_1.
- o_aluInputBSel  output  2  0 = REG_READ_DATA_2, 1 = IMMEDIATE_EXTENDED, 2 = FOUR.
- o_resultSel  output  2  0 = ALU_OUT (aluOutput_q), 1 = DATAMEMORY (data_q), 2 = ALU (aluOutput_d). The selected result feeds both nextPc and regWriteData.
- o_aluLogicOperation  output  4  ADD = 0000, SUB = 0001, AND = 0010, OR = 0011, SLT = 0101.
- o_illegalInstr  output  1  sticky illegal-opcode flag (see Configuration).

## Operation
States and their outputs. Enables not listed are 0; selects not listed are don't-care and are driven to 0.
- IDLE: all enables 0. Transitions to FETCH.
- FETCH: addressSrc = 0, instructionRegWrite = 1, A = PC, B = FOUR, ADD, resultSel = ALU, pcWriteEn = 1. Transitions to DECODE.
- DECODE: A = OLD_PC, B = IMM, ADD (computes the branch target into aluOutput_q).
  - Next state by opcode: LW/SW → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other opcode → see Configuration.
- MEMADR: A = RD1, B = IMM, ADD. Next state: MEMREAD if opcode is LW, else MEMWRITE.
- MEMREAD: addressSrc = 1, resultSel = ALU_OUT. Transitions to MEMWB.
- MEMWB: resultSel = DATAMEMORY, regWriteEn = 1. Transitions to FETCH.
- MEMWRITE: addressSrc = 1, memWriteEn = 1. Transitions to FETCH.
- EXECUTER: A = RD1, B = RD2, funct-decoded op. Transitions to ALUWB.
- EXECUTEI: A = RD1, B = IMM, funct-decoded op. Transitions to ALUWB.
- ALUWB: resultSel = ALU_OUT, regWriteEn = 1. Transitions to FETCH.
- BEQ: A = RD1, B = RD2, SUB, resultSel = ALU_OUT, pcWriteEn = i_zeroFlag. This is the only Mealy output. Transitions to FETCH.
- JAL: A = OLD_PC, B = FOUR, ADD, resultSel = ALU_OUT, pcWriteEn = 1. Transitions to ALUWB.

Funct decode (EXECUTER/EXECUTEI), keyed on funct3:
- 000: SUB only when EXECUTER and i_funct7bit5 = 1; otherwise ADD. In EXECUTEI, bit 30 is immediate, so it is always ADD.
- 010: SLT.
- 110: OR.
- 111: AND.
- Other funct3 values: ADD.

## Timing
- Reset: asynchronous assertion forces state to IDLE and o_illegalInstr to 0. While in reset, all enables are 0 and all selects are 0.
- Reset deassertion: first edge moves to IDLE→FETCH, so the first fetch occurs one cycle after release.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after assertion.
- Cycles per instruction, counted FETCH→FETCH: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- The state register is the only flop besides o_illegalInstr. All outputs are combinational decodes of state (plus opcode, funct, and zero where noted).

## Configuration
- MULTI_CYCLE_ILLEGAL_HALT_EN defined:
  - An illegal opcode in DECODE transitions to HALT.
  - HALT has all enables 0, sets o_illegalInstr = 1, and stays in HALT until reset.
- Undefined:
  - An illegal opcode in DECODE transitions to FETCH (executes as a NOP, with the PC already advanced by 4).
  - o_illegalInstr is tied to 0 and the HALT state does not exist.

## Structure
- pa_riscv package holds:
  - Opcode constants: LW, SW, RTYPE, ITYPE, BEQ, JAL.
  - aluInputA/B select enums.
  - resultSel enum.
  - 4-bit ALU operation constants.
  - The state enum typedef.
- Sub-module aluDecoder:
  - Inputs: 2-bit aluOp (ADD, SUB, FUNCT), i_funct3, i_funct7bit5, and an isRType flag.
  - Output: o_aluLogicOperation.
- The FSM, next-state logic and output decode live in multi_cycle_controller.

## Test plan
- Reset with i_arst_n low mid-cycle → all enables 0 immediately. Release → IDLE, then FETCH with instructionRegWrite = 1 and pcWriteEn = 1 on the following cycle.
- Opcode 0000011 (lw) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regWriteEn = 1 only in MEMWB, with resultSel = 1. Total 5 cycles.
- Opcode 0110011, funct3 000, funct7bit5 1 → SUB in EXECUTER. The same fields with opcode 0010011 → ADD. funct3 111 → AND (0010).
- Opcode 1100011 (beq) with zeroFlag = 1 → pcWriteEn = 1 in BEQ. With zeroFlag = 0 → pcWriteEn = 0. FETCH follows in both cases.
- Opcode 0100011 (sw) → memWriteEn = 1 for exactly one cycle (MEMWRITE) with addressSrc = 1. regWriteEn stays 0 throughout.
- Opcode 1111111:
  - With the macro: HALT and o_illegalInstr = 1, held for 10+ cycles until reset.
  - Without the macro: returns to FETCH after DECODE.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, mux selects, ALU ops, FSM states.
// The HALT state exists only when MULTI_CYCLE_ILLEGAL_HALT_EN is defined.
package pa_riscv;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  typedef enum logic [1:0] {
    ALU_A_PC     = 2'd0,
    ALU_A_OLD_PC = 2'd1,
    ALU_A_RD1    = 2'd2
  } alu_a_sel_e;

  typedef enum logic [1:0] {
    ALU_B_RD2  = 2'd0,
    ALU_B_IMM  = 2'd1,
    ALU_B_FOUR = 2'd2
  } alu_b_sel_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT = 2'd0,
    RES_DATAMEM = 2'd1,
    RES_ALU     = 2'd2
  } result_sel_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
`ifdef MULTI_CYCLE_ILLEGAL_HALT_EN
    ,
    S_HALT     = 4'd12
`endif
  } state_e;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decode: fixed ADD/SUB, or funct3/funct7 driven op for R- and I-type execute.
module aluDecoder
  import pa_riscv::*;
(
  input  logic [1:0] i_aluOp,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_isRType,
  output logic [3:0] o_aluLogicOperation
);

  // Map the controller's coarse request and the funct fields onto the ALU encoding
  always_comb begin
    o_aluLogicOperation = ALU_ADD;
    case (i_aluOp)
      ALUOP_ADD: o_aluLogicOperation = ALU_ADD;
      ALUOP_SUB: o_aluLogicOperation = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // bit 30 is part of the immediate for I-type, so only R-type may subtract
          3'b000: begin
            if (i_isRType && i_funct7bit5) begin
              o_aluLogicOperation = ALU_SUB;
            end else begin
              o_aluLogicOperation = ALU_ADD;
            end
          end
          3'b010:  o_aluLogicOperation = ALU_SLT;
          3'b110:  o_aluLogicOperation = ALU_OR;
          3'b111:  o_aluLogicOperation = ALU_AND;
          default: o_aluLogicOperation = ALU_ADD;
        endcase
      end
      default: o_aluLogicOperation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath (lw, sw, R, I, beq, jal).
// MULTI_CYCLE_ILLEGAL_HALT_EN: illegal opcodes halt the core and raise a sticky flag.
module multi_cycle_controller
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  output logic       o_pcWriteEn,
  output logic       o_instructionRegWrite,
  output logic       o_addressSrc,
  output logic       o_memWriteEn,
  output logic       o_regWriteEn,
  output logic [1:0] o_aluInputASel,
  output logic [1:0] o_aluInputBSel,
  output logic [1:0] o_resultSel,
  output logic [3:0] o_aluLogicOperation,
  output logic       o_illegalInstr
);

  state_e     state_r;
  state_e     state_next_s;
  logic [1:0] alu_op_s;
  logic       is_rtype_s;

  // Next-state selection; opcode is only consulted in DECODE and MEMADR
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  state_next_s = S_FETCH;
      S_FETCH: state_next_s = S_DECODE;
      S_DECODE: begin
        case (i_operand)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXECUTER;
          OP_ITYPE:     state_next_s = S_EXECUTEI;
          OP_BEQ:       state_next_s = S_BEQ;
          OP_JAL:       state_next_s = S_JAL;
`ifdef MULTI_CYCLE_ILLEGAL_HALT_EN
          default:      state_next_s = S_HALT;
`else
          default:      state_next_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (i_operand == OP_LW) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  state_next_s = S_MEMWB;
      S_MEMWB:    state_next_s = S_FETCH;
      S_MEMWRITE: state_next_s = S_FETCH;
      S_EXECUTER: state_next_s = S_ALUWB;
      S_EXECUTEI: state_next_s = S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BEQ:      state_next_s = S_FETCH;
      S_JAL:      state_next_s = S_ALUWB;
`ifdef MULTI_CYCLE_ILLEGAL_HALT_EN
      S_HALT:     state_next_s = S_HALT;
`endif
      default:    state_next_s = S_IDLE;
    endcase
  end

`ifdef MULTI_CYCLE_ILLEGAL_HALT_EN
  logic illegal_r;

  // State register plus the sticky illegal flag, which only reset can clear
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_r   <= S_IDLE;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s == S_HALT) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  assign o_illegalInstr = illegal_r;
`else
  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign o_illegalInstr = 1'b0;
`endif

  // Per-state datapath controls; BEQ's PC load is the single Mealy term
  always_comb begin
    o_pcWriteEn           = 1'b0;
    o_instructionRegWrite = 1'b0;
    o_addressSrc          = 1'b0;
    o_memWriteEn          = 1'b0;
    o_regWriteEn          = 1'b0;
    o_aluInputASel        = ALU_A_PC;
    o_aluInputBSel        = ALU_B_RD2;
    o_resultSel           = RES_ALU_OUT;
    alu_op_s              = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        o_instructionRegWrite = 1'b1;
        o_pcWriteEn           = 1'b1;
        o_aluInputASel        = ALU_A_PC;
        o_aluInputBSel        = ALU_B_FOUR;
        o_resultSel           = RES_ALU;
      end
      S_DECODE: begin
        o_aluInputASel = ALU_A_OLD_PC;
        o_aluInputBSel = ALU_B_IMM;
      end
      S_MEMADR: begin
        o_aluInputASel = ALU_A_RD1;
        o_aluInputBSel = ALU_B_IMM;
      end
      S_MEMREAD: begin
        o_addressSrc = 1'b1;
        o_resultSel  = RES_ALU_OUT;
      end
      S_MEMWB: begin
        o_resultSel  = RES_DATAMEM;
        o_regWriteEn = 1'b1;
      end
      S_MEMWRITE: begin
        o_addressSrc = 1'b1;
        o_memWriteEn = 1'b1;
      end
      S_EXECUTER: begin
        o_aluInputASel = ALU_A_RD1;
        o_aluInputBSel = ALU_B_RD2;
        alu_op_s       = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        o_aluInputASel = ALU_A_RD1;
        o_aluInputBSel = ALU_B_IMM;
        alu_op_s       = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_resultSel  = RES_ALU_OUT;
        o_regWriteEn = 1'b1;
      end
      S_BEQ: begin
        o_aluInputASel = ALU_A_RD1;
        o_aluInputBSel = ALU_B_RD2;
        alu_op_s       = ALUOP_SUB;
        o_resultSel    = RES_ALU_OUT;
        o_pcWriteEn    = i_zeroFlag;
      end
      S_JAL: begin
        o_aluInputASel = ALU_A_OLD_PC;
        o_aluInputBSel = ALU_B_FOUR;
        o_resultSel    = RES_ALU_OUT;
        o_pcWriteEn    = 1'b1;
      end
      default: begin
        o_pcWriteEn = 1'b0;
      end
    endcase
  end

  assign is_rtype_s = (state_r == S_EXECUTER);

  aluDecoder u_alu_decoder (
    .i_aluOp             (alu_op_s),
    .i_funct3            (i_funct3),
    .i_funct7bit5        (i_funct7bit5),
    .i_isRType           (is_rtype_s),
    .o_aluLogicOperation (o_aluLogicOperation)
  );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: per-instruction expected control sequences are queued and compared every cycle.
module tb_multi_cycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7;
  logic       zf;
  logic       pcw, irw, asrc, mw, rw, ill;
  logic [1:0] asel, bsel, rsel;
  logic [3:0] aop;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;
  exp_t q[$];

  multi_cycle_controller dut (
    .i_clk                 (clk),
    .i_arst_n              (rst_n),
    .i_operand             (opc),
    .i_funct3              (f3),
    .i_funct7bit5          (f7),
    .i_zeroFlag            (zf),
    .o_pcWriteEn           (pcw),
    .o_instructionRegWrite (irw),
    .o_addressSrc          (asrc),
    .o_memWriteEn          (mw),
    .o_regWriteEn          (rw),
    .o_aluInputASel        (asel),
    .o_aluInputBSel        (bsel),
    .o_resultSel           (rsel),
    .o_aluLogicOperation   (aop),
    .o_illegalInstr        (ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] actual();
    return {pcw, irw, asrc, mw, rw, asel, bsel, rsel, aop, ill};
  endfunction

  // pcw irw asrc mw rw | A B result | op | illegal
  function automatic logic [15:0] vec(bit p, bit i, bit a, bit m, bit r,
                                      int sa, int sb, int sr, int op, bit il);
    logic [1:0] xa, xb, xr;
    logic [3:0] xo;
    xa = sa[1:0]; xb = sb[1:0]; xr = sr[1:0]; xo = op[3:0];
    return {p, i, a, m, r, xa, xb, xr, xo, il};
  endfunction

  function automatic int exp_op(bit is_r, logic [2:0] fn3, logic fn7);
    if (fn3 == 3'b000) return (is_r && fn7) ? 1 : 0;
    if (fn3 == 3'b010) return 5;
    if (fn3 == 3'b110) return 3;
    if (fn3 == 3'b111) return 2;
    return 0;
  endfunction

  task automatic push(input string nm, input logic [15:0] v);
    exp_t e;
    e.v = v;
    e.name = nm;
    q.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting at its fetch cycle
  task automatic build(input logic [6:0] o, input logic [2:0] fn3, input logic fn7, input logic z);
    push("fetch",  vec(1, 1, 0, 0, 0, 0, 2, 2, 0, 0));
    push("decode", vec(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    case (o)
      7'b0000011: begin
        push("lw_addr", vec(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("lw_read", vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push("lw_wb",   vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      end
      7'b0100011: begin
        push("sw_addr",  vec(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("sw_write", vec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      end
      7'b0110011: begin
        push("r_exec", vec(0, 0, 0, 0, 0, 2, 0, 0, exp_op(1'b1, fn3, fn7), 0));
        push("r_wb",   vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end
      7'b0010011: begin
        push("i_exec", vec(0, 0, 0, 0, 0, 2, 1, 0, exp_op(1'b0, fn3, fn7), 0));
        push("i_wb",   vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end
      7'b1100011: push("beq", vec(z, 0, 0, 0, 0, 2, 0, 0, 1, 0));
      7'b1101111: begin
        push("jal",    vec(1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        push("jal_wb", vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end
      default: begin
`ifdef MULTI_CYCLE_ILLEGAL_HALT_EN
        for (int k = 0; k < 12; k++) push("halt", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
      end
    endcase
  endtask

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // probe_sel: 0 = ALU op, 1 = pcWriteEn, 2 = memWriteEn
  task automatic run_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                           input logic z, input int exp_len, input int limit,
                           input int probe, input int probe_sel, input logic [3:0] probe_val);
    int n0, n;
    logic [15:0] g;
    opc = o; f3 = fn3; f7 = fn7; zf = z;
    n0 = q.size();
    build(o, fn3, fn7, z);
    n = q.size() - n0;
    check("cpi_len", 16'(n), 16'(exp_len));
    if (limit >= 0) begin
      while (q.size() - n0 > limit) void'(q.pop_back());
      n = limit;
    end
    for (int c = 0; c < n; c++) begin
      if (c == probe) begin
        #1;
        if (probe_sel == 0) g = {12'h000, aop};
        else if (probe_sel == 1) g = {15'h0000, pcw};
        else g = {15'h0000, mw};
        check("probe", g, {12'h000, probe_val});
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", actual(), 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    check("reset_hold", actual(), 16'h0000);
    rst_n = 1'b1;
    push("idle", 16'h0000);
    @(posedge clk);
    #2;
  endtask

  // Single compare process: one queued expectation per cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (actual() !== e.v) begin
        bad++;
        $display("FAIL %s: got %h want %h at %0t", e.name, actual(), e.v, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    opc = 7'd0; f3 = 3'd0; f7 = 1'b0; zf = 1'b0;
    #2;
    do_reset();
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 5, -1, -1, 0, 4'h0);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4, -1, 3, 2, 4'h1);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4, -1, 2, 0, 4'b0001);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 4, -1, 2, 0, 4'b0000);
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 4, -1, 2, 0, 4'b0010);
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 4, -1, 2, 0, 4'b0011);
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 4, -1, 2, 0, 4'b0101);
    run_instr(7'b0110011, 3'b001, 1'b1, 1'b0, 4, -1, 2, 0, 4'b0000);
    run_instr(7'b0010011, 3'b111, 1'b1, 1'b0, 4, -1, 2, 0, 4'b0010);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3, -1, 2, 1, 4'h1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3, -1, 2, 1, 4'h0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 4, -1, 2, 1, 4'h1);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 5, -1, 4, 0, 4'h0);
`ifdef MULTI_CYCLE_ILLEGAL_HALT_EN
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 14, -1, -1, 0, 4'h0);
    check("halt_flag", {15'h0000, ill}, 16'h0001);
`else
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 2, -1, -1, 0, 4'h0);
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4, -1, 2, 0, 4'b0000);
`endif
    do_reset();
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3, -1, 0, 4'h0);
    check("sw_write_live", {15'h0000, mw}, 16'h0001);
    do_reset();
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4, -1, 2, 0, 4'b0001);
    check("queue_drained", 16'(q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
